gcd_controller: RTL

Control FSM that drives the subtractive GCD datapath. It accepts operand pairs from upstream on a valid/ready handshake and sequences load and subtract commands into the datapath from its compare/zero status flags. It returns completion with an iteration count and an error flag on a downstream valid/ready handshake. It sits between the request source and the datapath and replaces free-running datapath iteration with one subtraction per clock.

---
 rtl/gcd_pkg.sv | 20 ++
 rtl/gcd_controller_if.sv | 30 +++
 rtl/gcd_iter_counter.sv | 47 ++++
 rtl/gcd_controller.sv | 138 +++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg: constants and types shared by the GCD controller, its datapath and
// the testbench.
//   state_e      controller states IDLE, LOAD, CALC, DONE
//   OPERAND_W    datapath operand width
//   DEF_ITER_W   default iteration counter width (254 steps fit for 8-bit operands)
//   DEF_TIMEOUT  default iteration limit for the optional watchdog
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int OPERAND_W   = 8;
    localparam int DEF_ITER_W  = 9;
    localparam int DEF_TIMEOUT = 255;

endpackage : gcd_pkg

// File: rtl/gcd_controller_if.sv
// gcd_controller_if: request/response handshake bundle of the GCD controller.
//   req_valid/req_ready   upstream operand-pair handshake
//   rsp_valid/rsp_ready   downstream completion handshake
//   rsp_err               run aborted (zero operand or timeout)
//   iter_count            subtract commands issued in the current or last run
// Modports: master = request source / response sink, slave = controller.
interface gcd_controller_if
    import gcd_pkg::*;
#(
    parameter int ITER_W = DEF_ITER_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_err;
    logic [ITER_W-1:0] iter_count;

    modport master (
        output req_valid, rsp_ready,
        input  req_ready, rsp_valid, rsp_err, iter_count
    );

    modport slave (
        input  req_valid, rsp_ready,
        output req_ready, rsp_valid, rsp_err, iter_count
    );

endinterface : gcd_controller_if

// File: rtl/gcd_iter_counter.sv
// gcd_iter_counter: saturating iteration counter with clear, increment and a
// compare against a limit value.
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous clear (wins over inc)
//   inc          count one step; holds at all-ones instead of wrapping
//   limit        value compared against the current count
//   count        current count
//   at_limit     count == limit
module gcd_iter_counter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         at_limit
);

    logic [W-1:0] count_q, count_d;

    // NOTE: every always_comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign at_limit = (count_q == limit);

endmodule : gcd_iter_counter

// File: rtl/gcd_controller.sv
// gcd_controller: control FSM for the subtractive GCD datapath. Accepts an
// operand pair, loads the datapath, issues one subtraction per clock from the
// datapath status flags, and reports completion with an iteration count and an
// error flag.
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       req_valid/req_ready, rsp_valid/rsp_ready, rsp_err, iter_count
//   dp_load           datapath loads its operand inputs at the next edge
//   dp_sub_a/dp_sub_b datapath performs A-=B / B-=A at the next edge
//   dp_a_gt_b, dp_a_eq_b, dp_a_zero, dp_b_zero   registered datapath status
// Build option: define GCD_CTRL_TIMEOUT_EN to abort a run with rsp_err once
// iter_count reaches TIMEOUT.
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int ITER_W  = DEF_ITER_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    gcd_controller_if.slave  bus,
    output logic             dp_load,
    output logic             dp_sub_a,
    output logic             dp_sub_b,
    input  logic             dp_a_gt_b,
    input  logic             dp_a_eq_b,
    input  logic             dp_a_zero,
    input  logic             dp_b_zero
);

    state_e state_q, state_d;
    logic   req_ready_q, req_ready_d;
    logic   rsp_valid_q, rsp_valid_d;
    logic   rsp_err_q,   rsp_err_d;
    logic   dp_load_q,   dp_load_d;

    logic              accept;
    logic              in_calc;
    logic              zero_hit;
    logic              timeout_hit;
    logic              calc_stop;
    logic              at_limit;
    logic [ITER_W-1:0] iter_count;

`ifdef GCD_CTRL_TIMEOUT_EN
    assign timeout_hit = at_limit;
`else
    logic unused_at_limit;
    assign timeout_hit     = 1'b0;
    assign unused_at_limit = at_limit;
`endif

    assign accept    = req_ready_q && bus.req_valid;
    assign in_calc   = (state_q == CALC);
    // A zero operand is checked before equality so 0,0 is reported as an error.
    assign zero_hit  = dp_a_zero || dp_b_zero;
    assign calc_stop = zero_hit || dp_a_eq_b || timeout_hit;

    // NOTE: the subtract commands are decoded from the registered state and the
    // registered status flags, so they act in the same cycle the status is seen
    // (one subtraction per clock) and drop at once when reset clears state_q.
    assign dp_sub_a = in_calc && !calc_stop &&  dp_a_gt_b;
    assign dp_sub_b = in_calc && !calc_stop && !dp_a_gt_b;

    gcd_iter_counter #(
        .W (ITER_W)
    ) u_iter_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (accept),
        .inc      (dp_sub_a || dp_sub_b),
        .limit    (ITER_W'(TIMEOUT)),
        .count    (iter_count),
        .at_limit (at_limit)
    );

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        dp_load_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = LOAD;
                    req_ready_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    dp_load_d   = 1'b1;
                end
            end
            LOAD: begin
                state_d = CALC;
            end
            CALC: begin
                if (calc_stop) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = zero_hit || timeout_hit;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            dp_load_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            dp_load_q   <= dp_load_d;
        end
    end

    assign dp_load        = dp_load_q;
    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.iter_count = iter_count;

endmodule : gcd_controller
